// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the pulse-train generator.
package pulse_gen_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter shared by the high and low phases.
// A zero load value is treated as one, so every phase lasts at least one cycle.
// The counter is done when its count reaches one (terminal-count compare).
module phase_counter
   import pulse_gen_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expired,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Load (with zero promoted to one) or count down, parking at zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= (value == '0) ? ONE : value;
      end else if (count != '0) begin
         count <= count - ONE;
      end
   end

   assign expired = (count == ONE);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N pulses of H cycles active followed by
// L cycles idle, with continuous mode (N = 0), synchronous abort and status.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no train running; output at IDLE_LEVEL, waiting for start
//   ST_HIGH | active phase of the current pulse
//   ST_LOW  | idle phase after a pulse; pulse counted when it ends
//
// When the last low phase ends and start is present on that same edge, the
// next train is launched directly so back-to-back trains leave no extra gap.
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int   WIDTH      = DEF_WIDTH,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] high_len,
   input  logic [WIDTH-1:0] low_len,
   input  logic [WIDTH-1:0] pulses,
   output logic             signal,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] pulse_cnt
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] high_q;
   logic [WIDTH-1:0] low_q;
   logic [WIDTH-1:0] pulses_q;
   logic             cfg_latch;
   logic             cnt_load;
   logic [WIDTH-1:0] cnt_value;
   logic             cnt_expired;
   logic [WIDTH-1:0] cnt_count;
   logic [WIDTH-1:0] pulse_cnt_nxt;
   logic [WIDTH-1:0] pulse_cnt_inc;
   logic             last_pulse;
   logic             done_nxt;
   logic             signal_nxt;
   logic             busy_nxt;

   phase_counter #(
      .WIDTH (WIDTH)
   ) u_phase_counter (
      .clock   (clock),
      .reset   (reset),
      .load    (cnt_load),
      .value   (cnt_value),
      .expired (cnt_expired),
      .count   (cnt_count)
   );

   assign pulse_cnt_inc = pulse_cnt + ONE;
   assign last_pulse    = (pulses_q != '0) && (pulse_cnt_inc == pulses_q);

   // Next-state, counter-load and status decisions; stop always wins.
   always_comb begin
      state_nxt     = state;
      cfg_latch     = 1'b0;
      cnt_load      = 1'b0;
      cnt_value     = high_q;
      pulse_cnt_nxt = pulse_cnt;
      done_nxt      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !stop) begin
               state_nxt     = ST_HIGH;
               cfg_latch     = 1'b1;
               cnt_load      = 1'b1;
               cnt_value     = high_len;
               pulse_cnt_nxt = '0;
            end
         end
         ST_HIGH: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (cnt_expired) begin
               state_nxt = ST_LOW;
               cnt_load  = 1'b1;
               cnt_value = low_q;
            end
         end
         ST_LOW: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (cnt_expired) begin
               pulse_cnt_nxt = pulse_cnt_inc;
               if (last_pulse) begin
                  done_nxt = 1'b1;
                  if (start) begin
                     state_nxt     = ST_HIGH;
                     cfg_latch     = 1'b1;
                     cnt_load      = 1'b1;
                     cnt_value     = high_len;
                     pulse_cnt_nxt = '0;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  state_nxt = ST_HIGH;
                  cnt_load  = 1'b1;
                  cnt_value = high_q;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign signal_nxt = (state_nxt == ST_HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
   assign busy_nxt   = (state_nxt != ST_IDLE);

   // State register and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         signal    <= IDLE_LEVEL;
         busy      <= 1'b0;
         done      <= 1'b0;
         pulse_cnt <= '0;
      end else begin
         state     <= state_nxt;
         signal    <= signal_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         pulse_cnt <= pulse_cnt_nxt;
      end
   end

   // Configuration is captured only when a train is launched.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         high_q   <= '0;
         low_q    <= '0;
         pulses_q <= '0;
      end else if (cfg_latch) begin
         high_q   <= high_len;
         low_q    <= low_len;
         pulses_q <= pulses;
      end
   end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Programmable pulse-train generator. Emits `pulses` pulses, each `high_len` cycles high followed by `low_len` cycles low, then reports completion. It generalises the fixed 4-high/4-low testbench pulse into a synthesizable, run-time-configurable block with pulse counting, continuous mode, abort, and status outputs. It sits downstream of the shared clock and drives strobes, test stimuli and LED blink patterns.

## Interface
- `WIDTH`, 8: width of the length and count fields and of `pulse_cnt`.
- `IDLE_LEVEL`, 1'b0: level of `signal` when not generating. During the high phase the output is `~IDLE_LEVEL`.

- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: when sampled high in IDLE, latches the configuration and begins a train.
- `stop`, in, 1: synchronous abort.
- `high_len`, in, WIDTH: high-phase length in cycles. 0 is treated as 1.
- `low_len`, in, WIDTH: low-phase length in cycles. 0 is treated as 1.
- `pulses`, in, WIDTH: number of pulses. 0 means continuous until `stop`.
- `signal`, out, 1: pulse output, registered.
- `busy`, out, 1: high while a train is in progress.
- `done`, out, 1: one-cycle strobe when a finite train completes.
- `pulse_cnt`, out, WIDTH: number of completed pulses in the current or last train.

## Operation
- **FSM states:** IDLE, HIGH, LOW.
  - IDLE → HIGH: on `start` && !`stop`. Latch `high_len`, `low_len` and `pulses`, load the phase counter with `high_len`, clear `pulse_cnt`.
  - HIGH → LOW: when the phase counter expires. Load the counter with `low_len`.
  - LOW → HIGH: on counter expiry when pulses remain, or in continuous mode. `pulse_cnt` increments.
  - LOW → IDLE: on counter expiry of the last pulse. `pulse_cnt` increments and `done` = 1 for one cycle.
  - Any state → IDLE: on `stop`. No `done` is generated, `pulse_cnt` holds its value, and `signal` returns to `IDLE_LEVEL` at the same edge.
- **Configuration latching:** inputs are latched only at start. Changes to them while `busy` have no effect.
- **`start` while busy:** ignored.
- **`start` and `stop` together in IDLE:** `stop` wins and the block stays in IDLE.
- **Continuous mode:** `pulse_cnt` wraps modulo 2^WIDTH and `done` never asserts.
- **Length arithmetic:** all lengths are unsigned WIDTH-bit values. The maximum phase is 2^WIDTH−1 cycles.
- **Reset values:** IDLE, `signal` = `IDLE_LEVEL`, `busy` = 0, `done` = 0, `pulse_cnt` = 0, counters = 0.
- **Reset mid-train:** takes effect immediately and asynchronously, with no `done`.

## Timing
- **Start latency:** `start` sampled at edge k gives `signal` = active and `busy` = 1 from edge k. The first pulse is visible one cycle after the request (registered output).
- **Pulse timing:** with effective lengths H and L, pulse i (0-based) is active over edges k+i(H+L) to k+i(H+L)+H−1. It is idle for the next L cycles.
- **Finite-train completion:** for N pulses, `done` = 1 and `busy` = 0 after edge k+N(H+L). A new `start` is accepted at that same edge k+N(H+L), so back-to-back trains leave no idle gap beyond the final low phase.
- **Abort timing:** `stop` sampled at edge m gives `signal` = `IDLE_LEVEL` and `busy` = 0 after edge m.
- **Throughput:** one output transition per phase. The minimum period is 2 cycles (H = L = 1).

## Structure
- **Shared package `pulse_gen_pkg`:**
  - `state_t` enum (IDLE, HIGH, LOW).
  - Default `WIDTH` constant.
- **Sub-module `phase_counter` (WIDTH):**
  - Loadable down-counter with `load`, `value` and `expired` flag.
  - Substitutes 1 for a zero load value.
  - Instantiated once and shared by both phases.
- **Top level:** FSM, pulse counter, and output registers.

## Test plan
1. Reset release, idle: `reset` low then high, no `start` → `signal` = 0, `busy` = 0, `pulse_cnt` = 0 for 20 cycles.
2. Quadruple pattern: H=4, L=4, N=3, `start` at edge 10.
   - `signal` is high over edges 10–13, 18–21 and 26–29, and low otherwise.
   - `done` strobes after edge 34, with `pulse_cnt` = 3.
3. Zero lengths and odd duty: H=0, L=2, N=2 → high 1 / low 2 pattern, `done` after 6 cycles.
4. Continuous with abort: N=0, H=1, L=1, run 600 cycles then `stop`.
   - `pulse_cnt` wraps past 255.
   - `signal` = 0 and `busy` = 0 after the stop edge, with no `done`.
5. Ignored inputs: second `start` and a changed `high_len` while busy → the train is unchanged. `start` and `stop` together in IDLE → the block stays IDLE.
6. Asynchronous reset mid-HIGH: `reset` low between edges → `signal` = 0 and `busy` = 0 immediately, with no `done`.
